// File: rtl/register_file_scoreboard_if.sv
// rtl/register_file_scoreboard_if.sv - decode/writeback bus for the register file scoreboard
interface register_file_scoreboard_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2
);
   logic                           write_enable;
   logic [ADDR_WIDTH-1:0]          address_write;
   logic [DATA_WIDTH-1:0]          value_write;
   logic [NUM_READ*ADDR_WIDTH-1:0] address_read;
   logic [NUM_READ*DATA_WIDTH-1:0] value_read;
   logic [NUM_READ-1:0]            busy_read;
   logic                           reserve_enable;
   logic [ADDR_WIDTH-1:0]          address_reserve;
   logic                           flush;
   logic [ADDR_WIDTH:0]            busy_count;

   modport master (
      output write_enable, address_write, value_write, address_read,
      output reserve_enable, address_reserve, flush,
      input  value_read, busy_read, busy_count
   );

   modport slave (
      input  write_enable, address_write, value_write, address_read,
      input  reserve_enable, address_reserve, flush,
      output value_read, busy_read, busy_count
   );
endinterface

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - register file with write forwarding and pending-write scoreboard
module register_file_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter int ZERO_REG   = 1
) (
   input logic clk,
   input logic reset_n,
   register_file_scoreboard_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      busy_next;
   logic [DEPTH-1:0]      write_sel;
   logic [ADDR_WIDTH:0]   count_next;
   logic [ADDR_WIDTH-1:0] read_addr [NUM_READ];
   logic                  fwd_hit [NUM_READ];

   always_comb begin
      write_sel = '0;
      if (bus.write_enable) write_sel[bus.address_write] = 1'b1;
      if (ZERO_REG != 0) write_sel[0] = 1'b0;
   end

   // Reserve is applied after the write clear so the issuing instruction keeps ownership.
   always_comb begin
      busy_next = busy & ~write_sel;
      if (bus.reserve_enable) busy_next[bus.address_reserve] = 1'b1;
      if (bus.flush) busy_next = '0;
      if (ZERO_REG != 0) busy_next[0] = 1'b0;
   end

   always_comb begin
      count_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_next = count_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy           <= '0;
         bus.busy_count <= '0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         busy           <= busy_next;
         bus.busy_count <= count_next;
         for (int i = 0; i < DEPTH; i++) begin
            if (write_sel[i]) regs[i] <= bus.value_write;
         end
      end
   end

   for (genvar g = 0; g < NUM_READ; g++) begin : g_read
      assign read_addr[g] = bus.address_read[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign fwd_hit[g]   = bus.write_enable && (bus.address_write == read_addr[g]);
   end

   // A write in flight both forwards its data and hides the busy bit it is about to clear.
   always_comb begin
      bus.value_read = '0;
      bus.busy_read  = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         if (ZERO_REG != 0 && read_addr[i] == '0) begin
            bus.value_read[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         end else if (fwd_hit[i]) begin
            bus.value_read[i*DATA_WIDTH +: DATA_WIDTH] = bus.value_write;
         end else begin
            bus.value_read[i*DATA_WIDTH +: DATA_WIDTH] = regs[read_addr[i]];
         end
         bus.busy_read[i] = busy[read_addr[i]] && !fwd_hit[i];
      end
   end
endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
Parametrised successor of the CPU general-purpose register file. It provides a configurable data width, register count and number of read ports, and an optional hardwired zero register. It adds same-cycle write-to-read forwarding and a per-register pending-write scoreboard, which the decode stage uses to detect RAW hazards. Sits between decode (read and reserve) and writeback (write and release).

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register address bits; DEPTH = 2**ADDR_WIDTH registers
NUM_READ, 2, number of independent read ports (>=1)
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy; 0 = register 0 is ordinary

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
write_enable  input  1  commit value_write to address_write this edge
address_write  input  ADDR_WIDTH  writeback destination
value_write  input  DATA_WIDTH  writeback data
address_read  input  NUM_READ*ADDR_WIDTH  read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
value_read  output  NUM_READ*DATA_WIDTH  read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
busy_read  output  NUM_READ  port i's register has an outstanding reservation
reserve_enable  input  1  mark address_reserve as pending write
address_reserve  input  ADDR_WIDTH  register being claimed by an issuing instruction
flush  input  1  clear all reservations (pipeline flush)
busy_count  output  ADDR_WIDTH+1  number of registers currently reserved

Behaviour:
- Clock is clk; reset is synchronous and active-low on reset_n. While reset_n=0 at an edge, all registers load 0, all busy bits clear, and busy_count becomes 0. write, reserve and flush inputs are ignored on that edge.
- Storage: DEPTH x DATA_WIDTH flops with a one-hot write decode. A write to an address updates only that register at the edge.
- Read (combinational, zero latency), per port i with address a:
  - ZERO_REG=1 and a=0 -> value_read = 0.
  - Otherwise, if write_enable and address_write==a -> value_read = value_write (forward).
  - Otherwise -> value_read = stored value.
- Scoreboard: one busy bit per register.
  - Edge with reserve_enable: busy[address_reserve] <= 1.
  - Edge with write_enable: busy[address_write] <= 0.
  - Reserve and write to the same address on the same edge: set wins, so the bit ends at 1 (the newer instruction owns the register).
  - ZERO_REG=1: reserve or write of address 0 never sets its busy bit.
  - flush=1: all busy bits <= 0 and reserve_enable is ignored that edge. The data write still commits.
- busy_read[i] = busy[a] && !(write_enable && address_write==a), so it is consistent with forwarding. A reserve on the same cycle does not affect busy_read until the next cycle.
- busy_count: registered popcount of the busy bits, updated on the same edge as the bits and valid the cycle after. Range 0..DEPTH (DEPTH-1 when ZERO_REG=1). It never wraps.
- Reserving a register that is already busy: the bit stays 1 and the count is unchanged. Writing a register that is not busy: data updates and the busy bit stays 0.
- A reset asserted mid-sequence discards all pending reservations and data, with no partial state.

Test Plan:
1. Reset, then read all 32 registers on both ports -> every value_read=0, busy_read=0, busy_count=0.
2. Write x5=0xDEADBEEF while port0 reads x5 on the same cycle -> port0=0xDEADBEEF that cycle (forwarded) and again on the next cycle (stored). Write x0=0x1234 -> port1 reading x0 returns 0 on both cycles.
3. Reserve x7 at edge N -> busy_read=1 from cycle N+1 and busy_count=1. Write x7=0x55 at edge N+3 -> during that cycle busy_read=0 and value_read=0x55. After the edge, busy_count=0.
4. Reserve x9 and write x9=0xAA on the same edge -> x9 reads 0xAA and stays busy, busy_count=1. Then reserve x3 and x4, then flush together with reserve x6 -> busy_count=0 and x6 not busy.
5. Reserve x1 through x31 on consecutive edges -> busy_count=31. Reserve x0 -> count stays 31. Assert reset_n=0 for one edge -> all busy clear, count=0, all registers read 0.
6. Instantiate with DATA_WIDTH=64, ADDR_WIDTH=4, NUM_READ=3, ZERO_REG=0. Write x0=0x0123456789ABCDEF -> all three ports reading x0 return that value. Reserve x0 -> busy_read=1 on every port addressing x0.
